// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_CTRL_ADD = 4'b0000;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0001;
    localparam logic [3:0] ALU_CTRL_MUL = 4'b0010;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between the EX stage and the ALU.
// The overflow signal exists only when ALU_OVERFLOW_EN is defined.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_OVERFLOW_EN
    logic             overflow;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
`else
    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done pulses in the last busy cycle with product already showing the final sum.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_step;
    logic             busy;

    assign busy     = (count_q != '0);
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done     = busy && (count_q == CW'(1));
    assign product  = acc_step;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= CW'(WIDTH);
        end else if (busy) begin
            count_q <= count_q - CW'(1);
        end
    end

    // NOTE: datapath registers are not reset; they are always loaded on start
    // before being read, and the counter alone gates their use.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB, iterative MUL, registered result.
// Define ALU_OVERFLOW_EN to add the signed overflow flag.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);
    alu_state_e       state_q, state_d;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic             load;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;

    assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            ALU_CTRL_ADD: alu_res = bus.op_a + bus.op_b;
            ALU_CTRL_SUB: alu_res = bus.op_a - bus.op_b;
            default:      alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        load      = 1'b0;
        result_d  = alu_res;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.alu_ctrl == ALU_CTRL_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    load     = 1'b1;
                    result_d = mul_product;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending result is only overwritten by a load, which the in_ready
    // gating allows solely in the cycle the consumer takes the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            zero_q      <= (result_d == '0);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow only for ADD/SUB accepted in IDLE; MUL completions load 0.
    always_comb begin
        ovf_d = 1'b0;
        if (state_q == IDLE) begin
            case (bus.alu_ctrl)
                ALU_CTRL_ADD: ovf_d = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                                      (alu_res[WIDTH-1]  != bus.op_a[WIDTH-1]);
                ALU_CTRL_SUB: ovf_d = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                                      (alu_res[WIDTH-1]  != bus.op_a[WIDTH-1]);
                default:      ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake
// sequences and randomized traffic against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ovf;
    } exp_t;

    vec_t vecs[13];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, overflow judged by range.
    function automatic exp_t model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.res = '0;
        e.ovf = 1'b0;
        case (ctrl)
            4'd0: begin
                e.res = a + b;
                s     = sa + sb;
                e.ovf = (s > longint'(32'sh7fff_ffff)) || (s < longint'(32'sh8000_0000));
            end
            4'd1: begin
                e.res = a - b;
                s     = sa - sb;
                e.ovf = (s > longint'(32'sh7fff_ffff)) || (s < longint'(32'sh8000_0000));
            end
            4'd2: begin
                p     = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Issue one op with out_ready=1, measure latency and in_ready-low cycles.
    task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output logic ovf,
                          output int lat, output int busy);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = ctrl;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        lat  = 1;
        busy = 0;
        while (!bus.out_valid && lat < 200) begin
            if (!bus.in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        z   = bus.zero;
`ifdef ALU_OVERFLOW_EN
        ovf = bus.overflow;
`else
        ovf = 1'b0;
`endif
    endtask

    initial begin
        logic [31:0] r;
        logic        z, o;
        int          lat, busy, seen;
        logic [31:0] held;
        exp_t        e, got_e;
        logic        acc, hs;
        logic [3:0]  c;
        logic [31:0] ra, rb;
        int          sel;

        vecs[0]  = '{"add_5_7",      4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{"sub_9_9",      4'b0001, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[2]  = '{"sub_0_1",      4'b0001, 32'd0,          32'd1,          32'hffff_ffff,  1'b0, 1'b0};
        vecs[3]  = '{"mul_6_7",      4'b0010, 32'd6,          32'd7,          32'd42,         1'b0, 1'b0};
        vecs[4]  = '{"mul_ones_2",   4'b0010, 32'hffff_ffff,  32'd2,          32'hffff_fffe,  1'b0, 1'b0};
        vecs[5]  = '{"reserved_a",   4'b1010, 32'd123,        32'd456,        32'd0,          1'b1, 1'b0};
        vecs[6]  = '{"add_ovf",      4'b0000, 32'h7fff_ffff,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vecs[7]  = '{"sub_ovf",      4'b0001, 32'h8000_0000,  32'd1,          32'h7fff_ffff,  1'b0, 1'b1};
        vecs[8]  = '{"add_1_1",      4'b0000, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0};
        vecs[9]  = '{"mul_zero",     4'b0010, 32'd0,          32'hdead_beef,  32'd0,          1'b1, 1'b0};
        vecs[10] = '{"add_wrap",     4'b0000, 32'hffff_ffff,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[11] = '{"mul_x9",       4'b0010, 32'h1234_5678,  32'd9,          32'ha3d7_0a38,  1'b0, 1'b0};
        vecs[12] = '{"reserved_f",   4'b1111, 32'hffff_ffff,  32'hffff_ffff,  32'd0,          1'b1, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result",    64'(bus.result),    64'd0);
        check("reset_zero",      64'(bus.zero),      64'd0);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef ALU_OVERFLOW_EN
        check("reset_overflow",  64'(bus.overflow),  64'd0);
`endif
        reset = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, z, o, lat, busy);
            check({vecs[i].name, "_latency"}, 64'(lat),  (vecs[i].ctrl == 4'b0010) ? 64'(W + 1) : 64'd1);
            check({vecs[i].name, "_busy"},    64'(busy), (vecs[i].ctrl == 4'b0010) ? 64'(W) : 64'd0);
            check({vecs[i].name, "_result"},  64'(r),    64'(vecs[i].res));
            check({vecs[i].name, "_zero"},    64'(z),    64'(vecs[i].z));
`ifdef ALU_OVERFLOW_EN
            check({vecs[i].name, "_overflow"}, 64'(o),   64'(vecs[i].ovf));
`endif
        end

        // Back-to-back ADDs: one result per cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_valid",  64'(bus.out_valid), 64'd1);
                check("b2b_result", 64'(bus.result),    64'(32'(i - 1) * 32'd4));
            end
            check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
            bus.in_valid  = 1'b1;
            bus.alu_ctrl  = 4'b0000;
            bus.op_a      = 32'(i) * 32'd3;
            bus.op_b      = 32'(i);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_last", 64'(bus.result), 64'd16);

        // Backpressure: result held, in_ready low, queued op not lost
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = 4'b0000;
        bus.op_a      = 32'd100;
        bus.op_b      = 32'd1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.op_a = 32'd200;
        bus.op_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid",    64'(bus.out_valid), 64'd1);
            check("bp_result",   64'(bus.result),    64'd101);
            check("bp_in_ready", 64'(bus.in_ready),  64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_valid",  64'(bus.out_valid), 64'd1);
        check("bp_next_result", 64'(bus.result),    64'd202);
        @(negedge clk);
        check("bp_drop_valid",  64'(bus.out_valid), 64'd0);

        // Reset in the middle of a MUL aborts it
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 4'b0010;
        bus.op_a     = 32'd6;
        bus.op_b     = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_mul_busy", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        seen = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run_op(4'b0000, 32'd1, 32'd1, r, z, o, lat, busy);
        check("after_abort_result", 64'(r), 64'd2);
        check("after_abort_lat",    64'(lat), 64'd1);

        // Randomized traffic with scoreboard
        held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            sel = $urandom_range(0, 9);
            if (sel < 4)      c = 4'd0;
            else if (sel < 7) c = 4'd1;
            else if (sel < 9) c = 4'd2;
            else              c = 4'($urandom_range(3, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h7fff_ffff;
                1: rb = 32'h8000_0000;
                2: rb = 32'hffff_ffff;
                3: ra = 32'd0;
                default: ;
            endcase
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.alu_ctrl  = c;
            bus.op_a      = ra;
            bus.op_b      = rb;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            if (bus.out_valid && sb_q.size() == 0) begin
                check("rand_spurious_valid", 64'(bus.out_valid), 64'd0);
            end
            if (hs && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                got_e.res = bus.result;
                got_e.z   = bus.zero;
                check("rand_result", 64'(got_e.res), 64'(e.res));
                check("rand_zero",   64'(got_e.z),   64'(e.z));
`ifdef ALU_OVERFLOW_EN
                check("rand_overflow", 64'(bus.overflow), 64'(e.ovf));
`endif
            end
            if (acc) sb_q.push_back(model(c, ra, rb));
        end

        // Drain outstanding result
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) begin
                e = sb_q.pop_front();
                check("drain_result", 64'(bus.result), 64'(e.res));
                check("drain_zero",   64'(bus.zero),   64'(e.z));
            end
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
